// File: rtl/grf_pkg.sv
// rtl/grf_pkg.sv - shared MIPS register-file constants and register names
// Purpose: default widths for the general register file and the
//          architectural register indices used by decode and writeback.
// Ports:   none (package)
package grf_pkg;

  localparam int GRF_DW   = 32;
  localparam int GRF_AW   = 5;
  localparam int GRF_NREG = 1 << GRF_AW;

  // Architectural register names
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_AT   = 5'd1;
  localparam logic [4:0] REG_V0   = 5'd2;
  localparam logic [4:0] REG_V1   = 5'd3;
  localparam logic [4:0] REG_A0   = 5'd4;
  localparam logic [4:0] REG_T0   = 5'd8;
  localparam logic [4:0] REG_S0   = 5'd16;
  localparam logic [4:0] REG_GP   = 5'd28;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_FP   = 5'd30;
  localparam logic [4:0] REG_RA   = 5'd31;  // jal writeback target

endpackage

// File: rtl/grf_if.sv
// rtl/grf_if.sv - register file access bundle: two read ports, one write port, debug trace
// Purpose: groups the datapath-facing signals of grf.
// Signals: ra1/ra2 -> rd1/rd2 (combinational reads), we/wa/wd/pc (write),
//          dbg_wr/dbg_pc/dbg_wa/dbg_wd (registered write trace).
// Modports: master = datapath/writeback side, slave = grf.
interface grf_if
  import grf_pkg::*;
#(
  parameter int DW = GRF_DW,
  parameter int AW = GRF_AW
);

  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [31:0]   pc;
  logic          dbg_wr;
  logic [31:0]   dbg_pc;
  logic [AW-1:0] dbg_wa;
  logic [DW-1:0] dbg_wd;

  modport master (
    output ra1, ra2, we, wa, wd, pc,
    input  rd1, rd2, dbg_wr, dbg_pc, dbg_wa, dbg_wd
  );

  modport slave (
    input  ra1, ra2, we, wa, wd, pc,
    output rd1, rd2, dbg_wr, dbg_pc, dbg_wa, dbg_wd
  );

endinterface

// File: rtl/grf_read_port.sv
// rtl/grf_read_port.sv - one combinational read port of the register file
// Purpose: selects zero for index 0, the in-flight write data when bypass
//          is enabled and the indices match, otherwise the stored entry.
// Ports: ra (read index), mem_view (all entries, entry 0 reads as zero),
//        we/wa/wd (current write), rd (read data).
module grf_read_port
  import grf_pkg::*;
#(
  parameter int DW     = GRF_DW,
  parameter int AW     = GRF_AW,
  parameter bit BYPASS = 1'b1
) (
  input  logic [AW-1:0]                 ra,
  input  logic [(1<<AW)-1:0][DW-1:0]    mem_view,
  input  logic                          we,
  input  logic [AW-1:0]                 wa,
  input  logic [DW-1:0]                 wd,
  output logic [DW-1:0]                 rd
);

  always_comb begin
    rd = '0;
    if (ra == AW'(REG_ZERO)) begin
      rd = '0;
    end else if (BYPASS && we && (wa == ra)) begin
      rd = wd;
    end else begin
      rd = mem_view[ra];
    end
  end

endmodule

// File: rtl/grf.sv
// rtl/grf.sv - 32 x 32-bit MIPS general register file with write bypass and debug trace
// Purpose: two combinational read ports (rs/rt), one synchronous write
//          port from writeback, register 0 hardwired to zero.
// Ports: clk     - system clock, rising edge
//        reset_n - asynchronous active-low reset (clears entries and trace)
//        bus     - grf_if.slave: ra1/ra2/rd1/rd2, we/wa/wd/pc, dbg_*
module grf
  import grf_pkg::*;
#(
  parameter int DW     = GRF_DW,
  parameter int AW     = GRF_AW,
  parameter bit BYPASS = 1'b1
) (
  input  logic  clk,
  input  logic  reset_n,
  grf_if.slave  bus
);

  localparam int NREG = 1 << AW;

  // Entry 0 is never stored; it is supplied as a constant in mem_view.
  logic [DW-1:0]             mem [1:NREG-1];
  logic [NREG-1:0][DW-1:0]   mem_view;
  logic                      wr_commit;

  assign wr_commit = bus.we && (bus.wa != AW'(REG_ZERO));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_commit) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  always_comb begin
    mem_view[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      mem_view[i] = mem[i];
    end
  end

  grf_read_port #(.DW(DW), .AW(AW), .BYPASS(BYPASS)) u_port_a (
    .ra       (bus.ra1),
    .mem_view (mem_view),
    .we       (bus.we),
    .wa       (bus.wa),
    .wd       (bus.wd),
    .rd       (bus.rd1)
  );

  grf_read_port #(.DW(DW), .AW(AW), .BYPASS(BYPASS)) u_port_b (
    .ra       (bus.ra2),
    .mem_view (mem_view),
    .we       (bus.we),
    .wa       (bus.wa),
    .wd       (bus.wd),
    .rd       (bus.rd2)
  );

  // Write trace: strobe every edge, payload only captured on a real commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.dbg_wr <= 1'b0;
      bus.dbg_pc <= '0;
      bus.dbg_wa <= '0;
      bus.dbg_wd <= '0;
    end else begin
      bus.dbg_wr <= wr_commit;
      if (wr_commit) begin
        bus.dbg_pc <= bus.pc;
        bus.dbg_wa <= bus.wa;
        bus.dbg_wd <= bus.wd;
      end
    end
  end

endmodule

// File: tb/tb_grf.sv
// tb/tb_grf.sv - self-checking bench for grf, bypass and non-bypass builds side by side
module tb_grf;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  grf_if #(.DW(32), .AW(5)) bus_b ();
  grf_if #(.DW(32), .AW(5)) bus_n ();

  grf #(.DW(32), .AW(5), .BYPASS(1'b1)) u_byp (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  grf #(.DW(32), .AW(5), .BYPASS(1'b0)) u_nbyp (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_n)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural register contents and expected trace
  logic [31:0] model [32];
  logic        exp_wr;
  logic [31:0] exp_pc;
  logic [4:0]  exp_wa;
  logic [31:0] exp_wd;

  // Currently driven write-port values
  logic        cur_we;
  logic [4:0]  cur_wa;
  logic [31:0] cur_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (byp && cur_we && cur_wa == ra) return cur_wd;
    return model[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    exp_wr = 1'b0;
    exp_pc = 32'd0;
    exp_wa = 5'd0;
    exp_wd = 32'd0;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2, input logic [31:0] pc);
    cur_we = we; cur_wa = wa; cur_wd = wd;
    bus_b.we = we; bus_b.wa = wa; bus_b.wd = wd; bus_b.ra1 = ra1; bus_b.ra2 = ra2; bus_b.pc = pc;
    bus_n.we = we; bus_n.wa = wa; bus_n.wd = wd; bus_n.ra1 = ra1; bus_n.ra2 = ra2; bus_n.pc = pc;
  endtask

  task automatic check_reads(input logic [4:0] ra1, input logic [4:0] ra2);
    check("rd1_byp",  bus_b.rd1, exp_rd(1'b1, ra1));
    check("rd2_byp",  bus_b.rd2, exp_rd(1'b1, ra2));
    check("rd1_nbyp", bus_n.rd1, exp_rd(1'b0, ra1));
    check("rd2_nbyp", bus_n.rd2, exp_rd(1'b0, ra2));
  endtask

  task automatic commit_and_check_dbg(input logic [31:0] pc);
    if (cur_we && cur_wa != 5'd0) begin
      model[cur_wa] = cur_wd;
      exp_wr = 1'b1;
      exp_pc = pc;
      exp_wa = cur_wa;
      exp_wd = cur_wd;
    end else begin
      exp_wr = 1'b0;
    end
    check("dbg_wr_byp",  32'(bus_b.dbg_wr), 32'(exp_wr));
    check("dbg_pc_byp",  bus_b.dbg_pc, exp_pc);
    check("dbg_wa_byp",  32'(bus_b.dbg_wa), 32'(exp_wa));
    check("dbg_wd_byp",  bus_b.dbg_wd, exp_wd);
    check("dbg_wr_nbyp", 32'(bus_n.dbg_wr), 32'(exp_wr));
    check("dbg_pc_nbyp", bus_n.dbg_pc, exp_pc);
  endtask

  // One full cycle: drive at negedge, check reads, edge, check trace
  task automatic apply(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2, input logic [31:0] pc);
    @(negedge clk);
    drive(we, wa, wd, ra1, ra2, pc);
    #1;
    check_reads(ra1, ra2);
    @(posedge clk);
    #1;
    commit_and_check_dbg(pc);
  endtask

  initial begin
    model_reset();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Populate some registers so the reset pulse has something to clear
    for (int i = 1; i < 32; i += 3) apply(1'b1, 5'(i), 32'hDEAD_0000 + 32'(i), 5'd0, 5'd0, 32'h100 + 32'(i));

    // Asynchronous reset mid-cycle: all entries read zero without an edge
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      bus_b.ra1 = 5'(i); bus_b.ra2 = 5'(i);
      bus_n.ra1 = 5'(i); bus_n.ra2 = 5'(i);
      #0.1;
      check("rst_rd1", bus_b.rd1, 32'd0);
      check("rst_rd2", bus_n.rd2, 32'd0);
    end
    check("rst_dbg_wr", 32'(bus_b.dbg_wr), 32'd0);
    check("rst_dbg_pc", bus_b.dbg_pc, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Basic write then read
    apply(1'b1, 5'd8, 32'h1234_5678, 5'd0, 5'd0, 32'h0040_0000);
    check("basic_dbg_wr", 32'(bus_b.dbg_wr), 32'd1);
    check("basic_dbg_wa", 32'(bus_b.dbg_wa), 32'd8);
    apply(1'b0, 5'd0, 32'd0, 5'd8, 5'd8, 32'd0);
    check("basic_rd1", bus_b.rd1, 32'h1234_5678);

    // Writes to $0 are discarded
    apply(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'h0040_0004);
    check("zero_dbg_wr", 32'(bus_b.dbg_wr), 32'd0);
    check("zero_rd1", bus_b.rd1, 32'd0);

    // Same-cycle bypass
    apply(1'b1, 5'd9, 32'd5, 5'd0, 5'd0, 32'h0040_0008);
    @(negedge clk);
    drive(1'b1, 5'd9, 32'd7, 5'd9, 5'd9, 32'h0040_000C);
    #1;
    check("byp_rd1_pre",  bus_b.rd1, 32'd7);
    check("byp_rd2_pre",  bus_b.rd2, 32'd7);
    check("nbyp_rd1_pre", bus_n.rd1, 32'd5);
    check("nbyp_rd2_pre", bus_n.rd2, 32'd5);
    @(posedge clk);
    #1;
    commit_and_check_dbg(32'h0040_000C);
    check("nbyp_rd1_post", bus_n.rd1, 32'd7);
    check("nbyp_rd2_post", bus_n.rd2, 32'd7);

    // Reset held across an edge with a pending write
    @(negedge clk);
    drive(1'b1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd3, 32'h0040_0010);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstw_dbg_wr", 32'(bus_b.dbg_wr), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 32'd0);
    #1;
    check("rstw_rd1", bus_b.rd1, 32'd0);
    check("rstw_rd2", bus_n.rd2, 32'd0);

    // Full sweep
    for (int i = 1; i < 32; i++) begin
      apply(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'd0, 5'd0, 32'h3000 + 32'(4 * i));
      check("sweep_dbg_pc", bus_b.dbg_pc, 32'h3000 + 32'(4 * i));
    end
    for (int i = 0; i < 32; i++) begin
      apply(1'b0, 5'd0, 32'd0, 5'(i), 5'(i), 32'd0);
      check("sweep_rd1", bus_b.rd1, 32'(i) * 32'h0101_0101);
      check("sweep_rd2", bus_n.rd2, 32'(i) * 32'h0101_0101);
    end

    // Randomized traffic, biased toward index collisions
    for (int n = 0; n < 400; n++) begin
      logic        we;
      logic [4:0]  wa, ra1, ra2;
      we  = ($urandom_range(0, 3) != 0);
      wa  = 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31));
      apply(we, wa, $urandom, ra1, ra2, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
